// File: rtl/label_ram_arbiter.sv
// label_ram_arbiter
//
// Shares the single-port labels RAM between the display read path and a host
// write path. The display owns the port whenever it asks for it. Host writes
// are queued in a small FIFO and retired in free slots. A clear sequencer can
// fill the whole RAM with CLR_DATA.
//
// Optional feature macro: LABEL_ARB_VBLANK_ONLY_EN
//   defined   : FIFO pops and clear writes are granted only while vblank=1
//   undefined : vblank is ignored, every cycle with vga_req=0 is a write slot
//
// Ports
//   px_clk        pixel clock (only clock)
//   rst           synchronous active-high reset
//   vga_req       display needs the RAM this cycle
//   vga_addr      display read address
//   vga_data      RAM read data for the display (ram_dout passed through)
//   vga_rd_valid  vga_data belongs to the vga_req of the previous cycle
//   wr_valid      host write request
//   wr_ready      write queue can accept
//   wr_addr       host write address
//   wr_data       host write data
//   clr_req       single-cycle pulse starting a full-RAM clear
//   clr_busy      clear sequence in progress
//   vblank        vertical blanking indicator
//   ram_addr      RAM address
//   ram_we        RAM write enable
//   ram_din       RAM write data
//   ram_dout      RAM synchronous read data, 1-cycle latency
//   fifo_level    number of queued host writes

module label_ram_arbiter #(
  parameter int unsigned       ADDR_W     = 8,
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] CLR_DATA   = 8'h20
) (
  input  logic                          px_clk,
  input  logic                          rst,
  input  logic                          vga_req,
  input  logic [ADDR_W-1:0]             vga_addr,
  output logic [DATA_W-1:0]             vga_data,
  output logic                          vga_rd_valid,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          clr_req,
  output logic                          clr_busy,
  input  logic                          vblank,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic                          ram_we,
  output logic [DATA_W-1:0]             ram_din,
  input  logic [DATA_W-1:0]             ram_dout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned       PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned       LVL_W    = PTR_W + 1;
  localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] CLR_LAST = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {StIdle, StClear} state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  clr_cnt_q;
  logic               clr_busy_q;
  logic               rd_valid_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [LVL_W-1:0]   level_q;

  logic [ADDR_W-1:0]  fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]  fifo_data [FIFO_DEPTH];

  logic slot_ok;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic clr_grant;

  // Write-slot qualifier: either every display-free cycle, or only blanking.
`ifdef LABEL_ARB_VBLANK_ONLY_EN
  assign slot_ok = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign slot_ok       = 1'b1;
`endif

  assign fifo_full  = (level_q == LVL_FULL);
  assign fifo_empty = (level_q == '0);

  assign wr_ready = !fifo_full && !rst;
  assign push     = wr_valid && wr_ready;

  // The display request always wins; writes are also suppressed while in
  // reset so an aborted clear leaves the untouched region intact.
  assign clr_grant = !rst && !vga_req && slot_ok && (state_q == StClear);
  assign pop       = !rst && !vga_req && slot_ok && (state_q == StIdle) && !fifo_empty;

  always_comb begin
    ram_addr = vga_addr;
    ram_we   = 1'b0;
    ram_din  = '0;
    if (clr_grant) begin
      ram_addr = clr_cnt_q;
      ram_we   = 1'b1;
      ram_din  = CLR_DATA;
    end else if (pop) begin
      ram_addr = fifo_addr[rd_ptr_q];
      ram_we   = 1'b1;
      ram_din  = fifo_data[rd_ptr_q];
    end
  end

  assign vga_data     = ram_dout;
  assign vga_rd_valid = rd_valid_q;
  assign clr_busy     = clr_busy_q;
  assign fifo_level   = level_q;

  // Control FSM, clear counter, read-valid pipeline and FIFO bookkeeping.
  always_ff @(posedge px_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      clr_cnt_q  <= '0;
      clr_busy_q <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      rd_valid_q <= vga_req;

      unique case (state_q)
        StIdle: begin
          if (clr_req) begin
            state_q    <= StClear;
            clr_cnt_q  <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        StClear: begin
          // clr_req is deliberately ignored here; the counter only moves on
          // granted slots so stalls never skip an address.
          if (clr_grant) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (clr_cnt_q == CLR_LAST) begin
              state_q    <= StIdle;
              clr_busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q    <= StIdle;
          clr_busy_q <= 1'b0;
        end
      endcase

      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      // push is impossible when full and pop when empty, so the level
      // cannot leave 0..FIFO_DEPTH.
      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !push) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  // Queue storage needs no reset; entries are only read below level_q.
  always_ff @(posedge px_clk) begin
    if (push) begin
      fifo_addr[wr_ptr_q] <= wr_addr;
      fifo_data[wr_ptr_q] <= wr_data;
    end
  end

`ifndef SYNTHESIS
  // A write must never collide with a display fetch.
  a_no_we_on_vga : assert property (@(posedge px_clk) disable iff (rst) !(vga_req && ram_we));
  a_level_bound  : assert property (@(posedge px_clk) disable iff (rst) level_q <= LVL_FULL);
  a_no_clr_pop   : assert property (@(posedge px_clk) disable iff (rst)
                                    !(pop && (state_q == StClear)));
`endif

endmodule

// File: doc/label_ram_arbiter.md
# label_ram_arbiter

Shares the single-port labels RAM between the display read path and a host write path. The display always owns the port while a label pixel is being fetched. Host writes are queued in a small FIFO and retired in free slots. A built-in clear sequencer fills the whole RAM with a constant. The block sits between the last `vgaModule` in the label chain and the `ram` instance, and drives the RAM's addr/write_en/din.

## Interface
- `ADDR_W`, 8, RAM address width.
- `DATA_W`, 8, RAM data width.
- `FIFO_DEPTH`, 4, write-queue entries; power of two, ≥2.
- `CLR_DATA`, 8'h20, fill value written by the clear sequence.

- `px_clk` in 1: pixel clock, the only clock.
- `rst` in 1: synchronous, active-high reset.
- `vga_req` in 1: display needs the RAM this cycle (label-area flag of the stream).
- `vga_addr` in ADDR_W: display read address.
- `vga_data` out DATA_W: RAM read data for the display, `ram_dout` passed through.
- `vga_rd_valid` out 1: `vga_data` corresponds to the `vga_req` of the previous cycle.
- `wr_valid` in 1: host write request.
- `wr_ready` out 1: queue can accept.
- `wr_addr` in ADDR_W, `wr_data` in DATA_W: host write payload.
- `clr_req` in 1: single-cycle pulse that starts a full-RAM clear.
- `clr_busy` out 1: clear sequence in progress.
- `vblank` in 1: vertical blanking indicator (used only with the macro).
- `ram_addr` out ADDR_W, `ram_we` out 1, `ram_din` out DATA_W: RAM port.
- `ram_dout` in DATA_W: RAM synchronous read data, 1-cycle latency.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: queued entries.

## Operation
- FSM states: IDLE, CLEAR.
  - IDLE→CLEAR when `clr_req`=1.
  - CLEAR→IDLE on the cycle after address 2^ADDR_W−1 is written.
  - `clr_req` is ignored while in CLEAR.
- Slot grant, evaluated combinationally every cycle:
  1. `vga_req`=1 → `ram_addr`=`vga_addr`, `ram_we`=0. Display is never stalled.
  2. Else, in CLEAR → write `CLR_DATA` at the clear counter, then increment the counter.
  3. Else, in IDLE with the FIFO non-empty and write-eligible → pop the head and write it.
  4. Else → `ram_we`=0, `ram_addr`=`vga_addr`.
- Clear counter resets to 0 on entry to CLEAR and advances only on granted slots.
- FIFO is not popped during CLEAR. Pushes continue to be accepted, and those entries retire after the clear, in order.
- Push: `wr_valid && wr_ready`. `wr_ready` = !full && !rst.
- A push and a pop in the same cycle are legal when the FIFO is neither empty nor full. `fifo_level` is unchanged in that case.
- Pointers wrap modulo FIFO_DEPTH. `fifo_level` saturates by construction; there is no overflow or underflow path.
- Writes are FIFO-ordered. Two writes to the same address land in arrival order.

## Timing
- A pushed entry is write-eligible from the cycle after the push. Minimum push-to-RAM-write latency is 1 cycle.
- `vga_data` is valid the cycle after `vga_req`. `vga_rd_valid` is `vga_req` registered.
- A write and a same-address display read are never in the same cycle. A read after a write returns the new data.
- Full clear duration = 2^ADDR_W granted slots. `clr_busy` rises the cycle after `clr_req` and falls the cycle after the final write.
- Reset values: FSM=IDLE, FIFO empty, `fifo_level`=0, `clr_busy`=0, `vga_rd_valid`=0, `ram_we`=0, `wr_ready`=0 while `rst`=1.
- Reset mid-clear aborts the clear, leaving the RAM partially filled. Reset also discards queued writes.
- `clr_req` in the same cycle as `rst` is ignored.

## Configuration
- `LABEL_ARB_VBLANK_ONLY_EN`
  - Defined: FIFO pops, and clear writes, are granted only when `vblank`=1, giving tear-free label updates. If `vblank`=0 the queue holds and `wr_ready` falls when full.
  - Undefined: `vblank` is unused, and any cycle with `vga_req`=0 is a write slot.

## Test plan
- Reset, then push addr 8'h05/data 8'h41 with `vga_req`=0 → next cycle `ram_we`=1, `ram_addr`=8'h05, `ram_din`=8'h41; `fifo_level` returns to 0.
- Hold `vga_req`=1 and push 4 writes → `wr_ready`=0 after the 4th, no `ram_we` pulses. Drop `vga_req` → 4 writes in order on 4 consecutive cycles.
- `vga_req`=1 with `vga_addr`=8'h10 and `ram_dout` model 8'h33 → `vga_data`=8'h33 and `vga_rd_valid`=1 one cycle later.
- Pulse `clr_req` with `vga_req`=0 → 256 writes of 8'h20 to addresses 0..255, then `clr_busy`=0. A host write pushed mid-clear retires after address 255.
- Assert `rst` at clear address 8'h80 → `clr_busy`=0, `ram_we`=0, `fifo_level`=0 next cycle, and addresses ≥8'h80 are untouched.
- With the macro defined, push one write while `vblank`=0 → no write. Raise `vblank`=1 → write the next cycle.
